// File: rtl/mdio_responder.sv
// mdio_responder
// PHY-side Clause 22 MDIO management responder. MDC and MDIO are oversampled
// in the sys_clk domain (sys_clk must run at least 8x MDC). Decoded frames
// surface as single-cycle read/write strobes towards a local register bank.
//
// Ports:
//   sys_clk, sys_rst   system clock, synchronous active-high reset
//   mdc, mdio_i        management clock and MDIO pad input from the master
//   mdio_o, mdio_t     MDIO pad output value and tristate (1 = high-Z)
//   rd_strobe/rd_addr  read request; rd_data is sampled one cycle later
//   wr_strobe/wr_addr/wr_data  write commit
//   frame_err          pulse on malformed start or opcode
//
// Build option: define MDIO_RESP_BCAST_EN to also accept write frames
// addressed to PHYAD 5'h00 (broadcast write). Reads to 5'h00 stay ignored.
//
// state   | meaning
// IDLE    | counting preamble ones, waiting for ST bit 0
// START   | expecting ST bit 1
// OP      | shifting in the two opcode bits
// PHYAD   | shifting in and matching the PHY address
// REGAD   | shifting in the register address
// TA_RD   | read turnaround, bus still released on bit 14
// TA_WR   | write turnaround, two bits ignored
// RD_DATA | driving D15..D0, release after the last bit
// WR_DATA | shifting in D15..D0, commit after the last bit

module mdio_responder #(
    parameter logic [4:0] PHY_ADDR = 5'h01,
    parameter int         PRE_LEN  = 32
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    output logic        rd_strobe,
    output logic [4:0]  rd_addr,
    input  logic [15:0] rd_data,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err
);

    localparam int            PW      = $clog2(PRE_LEN + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRE_LEN);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_START   = 4'd1;
    localparam logic [3:0] S_OP      = 4'd2;
    localparam logic [3:0] S_PHYAD   = 4'd3;
    localparam logic [3:0] S_REGAD   = 4'd4;
    localparam logic [3:0] S_TA_RD   = 4'd5;
    localparam logic [3:0] S_TA_WR   = 4'd6;
    localparam logic [3:0] S_RD_DATA = 4'd7;
    localparam logic [3:0] S_WR_DATA = 4'd8;

    logic          mdc_s1, mdc_s2, mdc_s3;
    logic          mdio_s1, mdio_s2;
    logic          rise;
    logic          bit_s;
    logic [3:0]    state;
    logic [PW-1:0] pre_cnt;
    logic [4:0]    cnt;
    logic          is_rd;
    logic [15:0]   in_sh;
    logic [15:0]   rd_sh;
    logic [4:0]    reg_q;

    logic [4:0]    phy_in;
    logic          phy_match;

    // Address assembled from the four bits already shifted plus the current one
    always_comb begin
        phy_in    = {in_sh[3:0], bit_s};
        phy_match = (phy_in == PHY_ADDR);
`ifdef MDIO_RESP_BCAST_EN
        if (!is_rd && (phy_in == 5'h00)) begin
            phy_match = 1'b1;
        end
`else
        phy_match = phy_match;
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            // Synchronizers reset to the idle-high level so a high MDC at
            // reset release cannot produce a spurious rising edge.
            mdc_s1    <= 1'b1;
            mdc_s2    <= 1'b1;
            mdc_s3    <= 1'b1;
            mdio_s1   <= 1'b1;
            mdio_s2   <= 1'b1;
            rise      <= 1'b0;
            bit_s     <= 1'b1;
            state     <= S_IDLE;
            pre_cnt   <= '0;
            cnt       <= '0;
            is_rd     <= 1'b0;
            in_sh     <= '0;
            rd_sh     <= '0;
            reg_q     <= '0;
            mdio_o    <= 1'b0;
            mdio_t    <= 1'b1;
            rd_strobe <= 1'b0;
            rd_addr   <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            mdc_s1  <= mdc;
            mdc_s2  <= mdc_s1;
            mdc_s3  <= mdc_s2;
            mdio_s1 <= mdio_i;
            mdio_s2 <= mdio_s1;
            // rise and bit_s are registered together so the sampled bit is
            // the MDIO level aligned with the detected MDC edge.
            rise    <= mdc_s2 & ~mdc_s3;
            bit_s   <= mdio_s2;

            rd_strobe <= 1'b0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;

            if (rd_strobe) begin
                rd_sh <= rd_data;
            end

            if (rise) begin
                in_sh <= {in_sh[14:0], bit_s};
                cnt   <= cnt + 5'd1;
                case (state)
                    S_IDLE: begin
                        if (bit_s) begin
                            if (pre_cnt != PRE_MAX) begin
                                pre_cnt <= pre_cnt + PW'(1);
                            end
                        end else begin
                            if (pre_cnt == PRE_MAX) begin
                                state <= S_START;
                            end
                            pre_cnt <= '0;
                        end
                    end
                    S_START: begin
                        if (bit_s) begin
                            state <= S_OP;
                            cnt   <= '0;
                        end else begin
                            state     <= S_IDLE;
                            frame_err <= 1'b1;
                        end
                    end
                    S_OP: begin
                        if (cnt == 5'd1) begin
                            cnt <= '0;
                            case ({in_sh[0], bit_s})
                                2'b10: begin
                                    is_rd <= 1'b1;
                                    state <= S_PHYAD;
                                end
                                2'b01: begin
                                    is_rd <= 1'b0;
                                    state <= S_PHYAD;
                                end
                                default: begin
                                    state     <= S_IDLE;
                                    frame_err <= 1'b1;
                                end
                            endcase
                        end
                    end
                    S_PHYAD: begin
                        if (cnt == 5'd4) begin
                            cnt   <= '0;
                            state <= phy_match ? S_REGAD : S_IDLE;
                        end
                    end
                    S_REGAD: begin
                        if (cnt == 5'd4) begin
                            cnt   <= '0;
                            reg_q <= {in_sh[3:0], bit_s};
                            if (is_rd) begin
                                rd_strobe <= 1'b1;
                                rd_addr   <= {in_sh[3:0], bit_s};
                                state     <= S_TA_RD;
                            end else begin
                                state <= S_TA_WR;
                            end
                        end
                    end
                    S_TA_RD: begin
                        mdio_t <= 1'b0;
                        mdio_o <= 1'b0;
                        cnt    <= '0;
                        state  <= S_RD_DATA;
                    end
                    S_RD_DATA: begin
                        if (cnt == 5'd16) begin
                            mdio_t <= 1'b1;
                            mdio_o <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            mdio_o <= rd_sh[15];
                            rd_sh  <= {rd_sh[14:0], 1'b0};
                        end
                    end
                    S_TA_WR: begin
                        if (cnt == 5'd1) begin
                            cnt   <= '0;
                            state <= S_WR_DATA;
                        end
                    end
                    S_WR_DATA: begin
                        if (cnt == 5'd15) begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= reg_q;
                            wr_data   <= {in_sh[14:0], bit_s};
                            state     <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
